aes_128_round_ctrl: RTL and testbench

//  Round sequencer for the iterative AES-128 encrypt core: 1 initial AddRoundKey + NR rounds,

---
 rtl/aes_128_round_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_128_round_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/aes_128_round_ctrl.sv
// Round sequencer for the iterative AES-128 encrypt core: IDLE -> INIT -> NR rounds -> HOLD.
// Optional AES_ROUND_CTRL_ABORT_EN adds an abort input that returns the controller to IDLE.
module aes_128_round_ctrl #(
  parameter int NR         = 10,
  parameter int RND_PHASES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       sel_init,
  output logic       state_we,
  output logic       sbox_kill,
  output logic       key_step,
  output logic       last_round,
  output logic [3:0] round_cnt,
  output logic [1:0] phase,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_HOLD} state_t;

  localparam logic [3:0] NR_C    = 4'(NR);
  localparam logic [1:0] PH_LAST = 2'(RND_PHASES - 1);

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] ph_q, ph_d;
  logic       abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ph_d    = ph_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_INIT;
        rnd_d   = '0;
        ph_d    = '0;
      end
      S_INIT: begin
        state_d = S_ROUND;
        rnd_d   = 4'd1;
        ph_d    = '0;
      end
      S_ROUND: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          // round_cnt stays at NR through HOLD so the datapath still sees the last round key
          if (rnd_q == NR_C) state_d = S_HOLD;
          else               rnd_d   = rnd_q + 4'd1;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      S_HOLD: if (out_ready) begin
        state_d = S_IDLE;
        rnd_d   = '0;
        ph_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      rnd_d   = '0;
      ph_d    = '0;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sel_init   = 1'b0;
    state_we   = 1'b0;
    sbox_kill  = 1'b0;
    key_step   = 1'b0;
    last_round = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready  = 1'b1;
        sbox_kill = 1'b1;
      end
      S_INIT: begin
        sel_init = 1'b1;
        state_we = 1'b1;
        busy     = 1'b1;
      end
      S_ROUND: begin
        key_step   = (ph_q == 2'd0);
        state_we   = (ph_q == PH_LAST);
        last_round = (rnd_q == NR_C);
        busy       = 1'b1;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        sbox_kill = 1'b1;
      end
      default: ;
    endcase
    // an aborted cycle must not corrupt the state register or key schedule
    if (abort_hit) begin
      state_we = 1'b0;
      key_step = 1'b0;
    end
  end

  assign round_cnt = rnd_q;
  assign phase     = ph_q;

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// Randomized bench for aes_128_round_ctrl: cycle-offset reference model plus per-block literal checks.
module tb_aes_128_round_ctrl;
  localparam int NR   = 10;
  localparam int P    = 3;
  localparam int LAST = 1 + NR * P;   // offset of the final capture cycle
  localparam int HOLD = LAST + 1;

  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, sel_init, state_we, sbox_kill, key_step, last_round, busy;
  logic [3:0] round_cnt;
  logic [1:0] phase;
  logic       abort = 1'b0;

  aes_128_round_ctrl #(.NR(NR), .RND_PHASES(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .sel_init(sel_init), .state_we(state_we), .sbox_kill(sbox_kill), .key_step(key_step),
    .last_round(last_round), .round_cnt(round_cnt), .phase(phase), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mk = -1;       // cycles since accept: -1 idle, 1 init, 2..LAST rounds, HOLD waiting
  int cyc = 0;

  logic ab_en;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign ab_en = 1'b1;
`else
  assign ab_en = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mk = -1;
    else if (ab_en && abort && mk != -1) mk = -1;
    else if (mk == -1) begin
      if (in_valid) mk = 1;
    end else if (mk < HOLD) mk = mk + 1;
    else if (out_ready) mk = -1;
  end

  // {in_ready,out_valid,sel_init,state_we,sbox_kill,key_step,last_round,busy,round_cnt,phase}
  function automatic logic [13:0] exp_vec(input int m, input logic ab);
    logic [13:0] v;
    int r, p;
    v = '0;
    if (m == -1) begin
      v[13] = 1'b1; v[9] = 1'b1;
    end else if (m == 1) begin
      v[11] = 1'b1; v[10] = 1'b1; v[6] = 1'b1;
    end else if (m <= LAST) begin
      r = (m - 2) / P + 1;
      p = (m - 2) % P;
      v[10] = (p == P - 1);
      v[8]  = (p == 0);
      v[7]  = (r == NR);
      v[6]  = 1'b1;
      v[5:2] = 4'(r);
      v[1:0] = 2'(p);
    end else begin
      v[12] = 1'b1; v[9] = 1'b1; v[5:2] = 4'(NR);
    end
    if (ab && m != -1) begin
      v[10] = 1'b0; v[8] = 1'b0;
    end
    return v;
  endfunction

  // per-block statistics compared against hand-counted literals
  int  acc_cyc, n_key, n_we, n_kill, n_last;
  logic blk_on = 1'b0, prev_ov = 1'b0;

  task automatic lit(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic check_cycle();
    logic [13:0] act, exp;
    cyc++;
    act = {in_ready, out_valid, sel_init, state_we, sbox_kill, key_step, last_round, busy,
           round_cnt, phase};
    exp = exp_vec(mk, ab_en & abort);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle %0d outputs got %b want %b (model offset %0d)", cyc, act, exp, mk);
    end
    if (in_ready && out_valid) lit("ready_valid_exclusive", 1, 0);
    if (!rst_n) blk_on = 1'b0;
    else if (in_ready && in_valid) begin
      blk_on = 1'b1; acc_cyc = cyc; n_key = 0; n_we = 0; n_kill = 0; n_last = 0;
    end else if (blk_on) begin
      n_key  += int'(key_step);
      n_we   += int'(state_we);
      n_kill += int'(!sbox_kill);
      n_last += int'(last_round);
      if (out_valid && !prev_ov) begin
        lit("out_valid_latency", cyc - acc_cyc, 32);
        lit("key_step_count", n_key, 10);
        lit("state_we_count", n_we, 11);
        lit("sbox_kill_low_count", n_kill, 31);
        lit("last_round_count", n_last, 3);
        blk_on = 1'b0;
      end
    end
    prev_ov = out_valid;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic rst, input logic ab);
    logic was_up;
    @(posedge clk);
    #1;
    was_up    = rst_n;
    in_valid  = iv;
    out_ready = ordy;
    abort     = ab & ab_en;
    rst_n     = rst;
    if (was_up && !rst) begin
      #1;
      lit("reset_same_cycle_in_ready", int'(in_ready), 1);
      lit("reset_same_cycle_sbox_kill", int'(sbox_kill), 1);
      lit("reset_same_cycle_round_cnt", int'(round_cnt), 0);
    end
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // block with a stalled sink: HOLD must persist for 20 cycles
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 31 + 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    lit("hold_round_cnt", int'(round_cnt), 10);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // in_valid pulses while busy must be ignored
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    // reset at round 6 phase 1, then a fresh block
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    lit("pre_reset_round", int'(round_cnt), 6);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    // randomized traffic with occasional resets (and aborts when enabled)
    for (int i = 0; i < 3000; i++)
      step(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 500 != 0),
           1'($urandom % 40 == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
